// File: rtl/regfile_access_ctrl_if.sv
// Command/response bus between a requester and regfile_access_ctrl.
//   master : requester side; drives commands, consumes responses.
//   slave  : controller side; accepts commands, returns responses.
// Signals:
//   cmd_valid/cmd_ready   command handshake
//   cmd_write             1 = write, 0 = read
//   cmd_addr1/cmd_addr2   write address or read address 1 / read address 2
//   cmd_wdata             write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_data1/rsp_data2   response FIFO head
//   busy                  read in flight or responses queued
interface regfile_access_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr1;
  logic [ADDR_WIDTH-1:0] cmd_addr2;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data1;
  logic [DATA_WIDTH-1:0] rsp_data2;
  logic                  busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr1, cmd_addr2, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data1, rsp_data2, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr1, cmd_addr2, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data1, rsp_data2, busy
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Command front-end for a register file with one write port and two
// registered read ports (1-cycle read latency). Read data is captured one
// cycle after issue into a response FIFO and returned over a valid/ready
// handshake. Credit-based acceptance guarantees every accepted read has a
// free FIFO slot.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       command/response handshake bus, busy flag
//   rf_we             register-file write enable
//   rf_write_addr     register-file write address
//   rf_write_data     register-file write data
//   rf_read_addr1/2   register-file read addresses
//   rf_read_data1/2   register-file read data (valid the cycle after issue)
module regfile_access_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_access_ctrl_if.slave  bus,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [ADDR_WIDTH-1:0] rf_read_addr1,
  output logic [ADDR_WIDTH-1:0] rf_read_addr2,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic [DATA_WIDTH-1:0] rf_read_data2
);

  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RSP_DEPTH);

  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic                    r_rd_inflight;
  logic [2*DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];

  logic [CNT_W:0]          w_credit_used;
  logic                    w_cmd_ready;
  logic                    w_accept;
  logic                    w_rd_accept;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_rsp_valid;

  // Outstanding reads (queued + in flight) must leave a slot free before
  // anything new is accepted; writes are held to the same rule for ordering.
  assign w_credit_used = {1'b0, r_count} + (CNT_W + 1)'(r_rd_inflight);
  assign w_cmd_ready   = rst_n & (w_credit_used < DEPTH_C);
  assign w_accept      = bus.cmd_valid & w_cmd_ready;
  assign w_rd_accept   = w_accept & ~bus.cmd_write;

  assign w_rsp_valid   = (r_count != '0);
  assign w_push        = r_rd_inflight;
  assign w_pop         = w_rsp_valid & bus.rsp_ready;

  assign rf_we         = w_accept & bus.cmd_write;
  assign rf_write_addr = bus.cmd_addr1;
  assign rf_write_data = bus.cmd_wdata;
  assign rf_read_addr1 = bus.cmd_addr1;
  assign rf_read_addr2 = bus.cmd_addr2;

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.busy      = r_rd_inflight | w_rsp_valid;

  // Head is masked when empty so stale storage never shows on the bus,
  // including while reset is asserted.
  always_comb begin
    {bus.rsp_data1, bus.rsp_data2} = '0;
    if (w_rsp_valid) begin
      {bus.rsp_data1, bus.rsp_data2} = r_fifo[r_rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {rf_read_data1, rf_read_data2};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rd_inflight <= 1'b0;
    end else begin
      r_rd_inflight <= w_rd_accept;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a behavioural register file, a reference
// model (register array plus a queue of expected responses tagged with the
// cycle they were accepted), and directed plus random stimulus.
module tb_regfile_access_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned RSP_DEPTH = 4;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    int            cyc;
  } rsp_t;

  logic          clk;
  logic          rst_n;
  logic          rf_we;
  logic [AW-1:0] rf_write_addr;
  logic [DW-1:0] rf_write_data;
  logic [AW-1:0] rf_read_addr1;
  logic [AW-1:0] rf_read_addr2;
  logic [DW-1:0] rf_read_data1;
  logic [DW-1:0] rf_read_data2;

  regfile_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_access_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .rf_we        (rf_we),
    .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .rf_read_addr1(rf_read_addr1),
    .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1),
    .rf_read_data2(rf_read_data2)
  );

  // Register file: one write port, two registered read ports.
  logic [DW-1:0] rf_mem [16];
  always_ff @(posedge clk) begin
    if (rf_we) rf_mem[rf_write_addr] <= rf_write_data;
    rf_read_data1 <= rf_mem[rf_read_addr1];
    rf_read_data2 <= rf_mem[rf_read_addr2];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   now   = 0;
  logic [DW-1:0] ref_mem [16];
  rsp_t exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered just after a falling edge with inputs driven.
  task automatic cycle(output bit acc);
    bit   exp_ready, exp_valid, pop;
    rsp_t r;
    #1;
    exp_ready = (exp_q.size() < RSP_DEPTH);
    exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= now);
    acc = bus.cmd_valid && exp_ready;
    pop = exp_valid && bus.rsp_ready;
    chk("cmd_ready", bus.cmd_ready, exp_ready);
    chk("rsp_valid", bus.rsp_valid, exp_valid);
    chk("busy", bus.busy, exp_q.size() > 0);
    chk("rf_we", rf_we, acc && bus.cmd_write);
    if (exp_valid) begin
      chk("rsp_data1", bus.rsp_data1, exp_q[0].d1);
      chk("rsp_data2", bus.rsp_data2, exp_q[0].d2);
    end
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      if (bus.cmd_write) begin
        ref_mem[bus.cmd_addr1] = bus.cmd_wdata;
      end else begin
        r.d1  = ref_mem[bus.cmd_addr1];
        r.d2  = ref_mem[bus.cmd_addr2];
        r.cyc = now;
        exp_q.push_back(r);
      end
    end
    @(posedge clk);
    now++;
    @(negedge clk);
  endtask

  task automatic set_cmd(input bit v, input bit w, input int a1, input int a2, input int wd);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr1 = AW'(a1);
    bus.cmd_addr2 = AW'(a2);
    bus.cmd_wdata = DW'(wd);
  endtask

  task automatic drain();
    bit acc;
    set_cmd(0, 0, 0, 0, 0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(acc);
    cycle(acc);
    chk("drained_busy", bus.busy, 1'b0);
  endtask

  initial begin
    bit acc;
    int n, guard, accepts;
    bit hold;

    rst_n = 1'b0;
    set_cmd(1, 1, 5, 0, 8'h3C);
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rsp_data", {bus.rsp_data1, bus.rsp_data2}, 16'h0);
    set_cmd(0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Initialise every register (addr 0 gets 0x00).
    for (int i = 0; i < 16; i++) begin
      set_cmd(1, 1, i, 0, i * 17);
      cycle(acc);
    end

    // Write then immediately read the same address.
    set_cmd(1, 1, 3, 0, 8'hA5);
    cycle(acc);
    set_cmd(1, 0, 3, 0, 0);
    cycle(acc);
    set_cmd(0, 0, 0, 0, 0);
    cycle(acc);
    chk("wr_rd_valid", bus.rsp_valid, 1'b1);
    chk("wr_rd_d1", bus.rsp_data1, 8'hA5);
    chk("wr_rd_d2", bus.rsp_data2, 8'h00);
    drain();

    // Back-to-back reads with the consumer always ready.
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1, 0, i, 3 - i, 0);
      cycle(acc);
    end
    drain();

    // Consumer stalled: only RSP_DEPTH reads get in.
    bus.rsp_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      set_cmd(1, 0, accepts + 4, accepts, 0);
      cycle(acc);
      if (acc) accepts++;
    end
    chk("stall_accepts", accepts, 4);
    drain();

    // Sustained reads through a near-full FIFO, wrapping the pointers.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1, 0, i + 8, i, 0);
      cycle(acc);
    end
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_cmd(1, 0, (i * 5) % 16, (i * 3) % 16, 0);
      cycle(acc);
    end
    drain();

    // Reset with two queued responses and one read in flight.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1, 0, i + 1, i + 2, 0);
      cycle(acc);
    end
    set_cmd(1, 1, 7, 0, 8'hEE);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("mid_rst_rf_we", rf_we, 1'b0);
    exp_q.delete();
    set_cmd(0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
    set_cmd(1, 0, 3, 7, 0);
    cycle(acc);
    set_cmd(0, 0, 0, 0, 0);
    cycle(acc);
    cycle(acc);
    chk("post_rst_d1", bus.rsp_data1, 8'hA5);
    chk("post_rst_d2", bus.rsp_data2, 8'h77);
    drain();

    // Random commands with toggling valid and randomised consumer.
    n = 0;
    guard = 0;
    hold = 0;
    while (n < 1000 && guard < 20000) begin
      if (!hold) begin
        set_cmd($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cycle(acc);
      if (acc) n++;
      hold = bus.cmd_valid && !acc;
      guard++;
    end
    chk("rand_cmds_done", n, 1000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
